// File: rtl/bouncing_screensaver.sv
// Bouncing sprite screensaver: sits between vga_timer and a bank of image ROMs, draws one
// sprite at native scale, bounces it by STEP pixels per frame and switches images only on
// frame boundaries. Pixel path: stage A (hit test + address), ROM_LATENCY carry stages,
// registered colour/sync output.
module bouncing_screensaver #(
  parameter int unsigned NUM_IMAGES        = 4,
  parameter int unsigned IMAGE_WIDTH       = 160,
  parameter int unsigned IMAGE_HEIGHT      = 120,
  parameter int unsigned SCREEN_WIDTH      = 640,
  parameter int unsigned SCREEN_HEIGHT     = 480,
  parameter int unsigned STEP              = 1,
  parameter int unsigned ROM_LATENCY       = 1,
  parameter int unsigned AUTO_CYCLE_FRAMES = 600,
  parameter logic [11:0] BG_COLOR          = 12'h000,
  localparam int unsigned AW               = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
  localparam int unsigned IW               = $clog2(NUM_IMAGES)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [9:0]               position_x_i,
  input  logic [9:0]               position_y_i,
  input  logic                     visible_i,
  input  logic                     hsync_i,
  input  logic                     vsync_i,
  input  logic [NUM_IMAGES-1:0]    select_image_i,
  input  logic                     auto_cycle_i,
  input  logic                     pause_i,
  output logic [AW-1:0]            rom_addr_o,
  input  logic [12*NUM_IMAGES-1:0] rom_rdata_i,
  output logic [3:0]               vga_red_o,
  output logic [3:0]               vga_green_o,
  output logic [3:0]               vga_blue_o,
  output logic                     vga_hsync_o,
  output logic                     vga_vsync_o,
  output logic                     frame_tick_o,
  output logic [IW-1:0]            active_image_o
);

  // Coordinate width and one extra bit so origin+size comparisons never wrap.
  localparam int unsigned CW   = 10;
  localparam int unsigned EW   = CW + 1;
  localparam int unsigned LAT  = ROM_LATENCY;
  localparam int unsigned CNTW = $clog2(AUTO_CYCLE_FRAMES + 1);

  localparam logic [CW-1:0]         MAX_X    = CW'(SCREEN_WIDTH - IMAGE_WIDTH);
  localparam logic [CW-1:0]         MAX_Y    = CW'(SCREEN_HEIGHT - IMAGE_HEIGHT);
  localparam logic [CW-1:0]         STEP_C   = CW'(STEP);
  localparam logic [EW-1:0]         W_E      = EW'(IMAGE_WIDTH);
  localparam logic [EW-1:0]         H_E      = EW'(IMAGE_HEIGHT);
  localparam logic [AW-1:0]         W_A      = AW'(IMAGE_WIDTH);
  localparam logic [CNTW-1:0]       CNT_LAST = CNTW'(AUTO_CYCLE_FRAMES - 1);
  localparam logic [IW-1:0]         IMG_LAST = IW'(NUM_IMAGES - 1);
  localparam logic [NUM_IMAGES-1:0] SEL_ONE  = NUM_IMAGES'(1);

  // ---------------------------------------------------------------------------------------
  // Frame boundary detection
  // ---------------------------------------------------------------------------------------
  logic r_vs_prev;
  logic r_frame_tick;
  logic w_tick;

  assign w_tick = r_vs_prev & ~vsync_i;

  // Register vsync for edge detection and delay the tick by one cycle for the output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vs_prev    <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_vs_prev    <= vsync_i;
      r_frame_tick <= w_tick;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Image selection
  // ---------------------------------------------------------------------------------------
  logic            w_sel_valid;
  logic [IW-1:0]   w_sel_idx;
  logic [IW-1:0]   r_pending;
  logic [IW-1:0]   r_active;
  logic [CNTW-1:0] r_frame_cnt;

  // Decode the manual select; only an exactly one-hot vector counts as a request.
  always_comb begin
    w_sel_valid = (select_image_i != '0) &&
                  ((select_image_i & (select_image_i - SEL_ONE)) == '0);
    w_sel_idx   = '0;
    for (int k = 0; k < NUM_IMAGES; k++) begin
      if (select_image_i[k]) begin
        w_sel_idx = IW'(k);
      end
    end
  end

  // Pending image follows manual select or the auto-cycle timer; active latches on a tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending   <= '0;
      r_active    <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_sel_valid) begin
        // Manual select wins over a coincident auto-cycle step and restarts the timer.
        r_pending   <= w_sel_idx;
        r_frame_cnt <= '0;
      end else if (w_tick && auto_cycle_i) begin
        if (r_frame_cnt == CNT_LAST) begin
          r_frame_cnt <= '0;
          r_pending   <= (r_pending == IMG_LAST) ? '0 : r_pending + 1'b1;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
      if (w_tick) begin
        r_active <= r_pending;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Sprite motion
  // ---------------------------------------------------------------------------------------
  logic [CW-1:0] r_org_x;
  logic [CW-1:0] r_org_y;
  logic          r_dir_x_pos;
  logic          r_dir_y_pos;
  logic [CW-1:0] w_org_x_nxt;
  logic [CW-1:0] w_org_y_nxt;
  logic          w_dir_x_nxt;
  logic          w_dir_y_nxt;
  logic [EW-1:0] w_x_sum;
  logic [EW-1:0] w_y_sum;

  // Next origin/direction per axis: clamp at the wall and reverse in the same frame.
  always_comb begin
    w_x_sum     = {1'b0, r_org_x} + {1'b0, STEP_C};
    w_y_sum     = {1'b0, r_org_y} + {1'b0, STEP_C};
    w_org_x_nxt = r_org_x;
    w_dir_x_nxt = r_dir_x_pos;
    w_org_y_nxt = r_org_y;
    w_dir_y_nxt = r_dir_y_pos;

    if (r_dir_x_pos) begin
      if (w_x_sum >= {1'b0, MAX_X}) begin
        w_org_x_nxt = MAX_X;
        w_dir_x_nxt = 1'b0;
      end else begin
        w_org_x_nxt = w_x_sum[CW-1:0];
      end
    end else begin
      if (r_org_x <= STEP_C) begin
        w_org_x_nxt = '0;
        w_dir_x_nxt = 1'b1;
      end else begin
        w_org_x_nxt = r_org_x - STEP_C;
      end
    end

    if (r_dir_y_pos) begin
      if (w_y_sum >= {1'b0, MAX_Y}) begin
        w_org_y_nxt = MAX_Y;
        w_dir_y_nxt = 1'b0;
      end else begin
        w_org_y_nxt = w_y_sum[CW-1:0];
      end
    end else begin
      if (r_org_y <= STEP_C) begin
        w_org_y_nxt = '0;
        w_dir_y_nxt = 1'b1;
      end else begin
        w_org_y_nxt = r_org_y - STEP_C;
      end
    end
  end

  // Move the sprite once per frame unless paused.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_org_x     <= '0;
      r_org_y     <= '0;
      r_dir_x_pos <= 1'b1;
      r_dir_y_pos <= 1'b1;
    end else if (w_tick && !pause_i) begin
      r_org_x     <= w_org_x_nxt;
      r_org_y     <= w_org_y_nxt;
      r_dir_x_pos <= w_dir_x_nxt;
      r_dir_y_pos <= w_dir_y_nxt;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Stage A: hit test and ROM address
  // ---------------------------------------------------------------------------------------
  logic [EW-1:0] w_px_e;
  logic [EW-1:0] w_py_e;
  logic [EW-1:0] w_ox_e;
  logic [EW-1:0] w_oy_e;
  logic [CW-1:0] w_dx;
  logic [CW-1:0] w_dy;
  logic          w_inside;
  logic [AW-1:0] w_addr;

  logic [AW-1:0] r_rom_addr;
  logic          r_a_inside;
  logic          r_a_vis;
  logic          r_a_hs;
  logic          r_a_vs;
  logic [IW-1:0] r_a_act;

  // Offsets are only meaningful when inside, which bounds them below W and H.
  always_comb begin
    w_px_e   = {1'b0, position_x_i};
    w_py_e   = {1'b0, position_y_i};
    w_ox_e   = {1'b0, r_org_x};
    w_oy_e   = {1'b0, r_org_y};
    w_inside = visible_i &&
               (w_px_e >= w_ox_e) && (w_px_e < w_ox_e + W_E) &&
               (w_py_e >= w_oy_e) && (w_py_e < w_oy_e + H_E);
    w_dx     = position_x_i - r_org_x;
    w_dy     = position_y_i - r_org_y;
    w_addr   = w_inside ? (AW'(w_dy) * W_A + AW'(w_dx)) : '0;
  end

  // Register the address with its sideband so both start the ROM latency together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rom_addr <= '0;
      r_a_inside <= 1'b0;
      r_a_vis    <= 1'b0;
      r_a_hs     <= 1'b1;
      r_a_vs     <= 1'b1;
      r_a_act    <= '0;
    end else begin
      r_rom_addr <= w_addr;
      r_a_inside <= w_inside;
      r_a_vis    <= visible_i;
      r_a_hs     <= hsync_i;
      r_a_vs     <= vsync_i;
      r_a_act    <= r_active;
    end
  end

  assign rom_addr_o = r_rom_addr;

  // ---------------------------------------------------------------------------------------
  // Stage B: sideband delay matching the ROM read latency
  // ---------------------------------------------------------------------------------------
  logic          r_b_inside [LAT];
  logic          r_b_vis    [LAT];
  logic          r_b_hs     [LAT];
  logic          r_b_vs     [LAT];
  logic [IW-1:0] r_b_act    [LAT];

  // Shift sideband so its last stage lines up with valid rom_rdata_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LAT; i++) begin
        r_b_inside[i] <= 1'b0;
        r_b_vis[i]    <= 1'b0;
        r_b_hs[i]     <= 1'b1;
        r_b_vs[i]     <= 1'b1;
        r_b_act[i]    <= '0;
      end
    end else begin
      r_b_inside[0] <= r_a_inside;
      r_b_vis[0]    <= r_a_vis;
      r_b_hs[0]     <= r_a_hs;
      r_b_vs[0]     <= r_a_vs;
      r_b_act[0]    <= r_a_act;
      for (int i = 1; i < LAT; i++) begin
        r_b_inside[i] <= r_b_inside[i-1];
        r_b_vis[i]    <= r_b_vis[i-1];
        r_b_hs[i]     <= r_b_hs[i-1];
        r_b_vs[i]     <= r_b_vs[i-1];
        r_b_act[i]    <= r_b_act[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------------------
  logic [11:0] w_pix;
  logic [11:0] w_rgb;
  logic [11:0] r_rgb;
  logic        r_hsync;
  logic        r_vsync;

  // Pick the displayed image's ROM word, then apply sprite/background/blanking priority.
  always_comb begin
    w_pix = '0;
    for (int k = 0; k < NUM_IMAGES; k++) begin
      if (r_b_act[LAT-1] == IW'(k)) begin
        w_pix = rom_rdata_i[12*k +: 12];
      end
    end
    if (r_b_inside[LAT-1]) begin
      w_rgb = w_pix;
    end else if (r_b_vis[LAT-1]) begin
      w_rgb = BG_COLOR;
    end else begin
      w_rgb = '0;
    end
  end

  // Register colour and syncs together so they leave aligned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rgb   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_rgb   <= w_rgb;
      r_hsync <= r_b_hs[LAT-1];
      r_vsync <= r_b_vs[LAT-1];
    end
  end

  assign vga_red_o      = r_rgb[11:8];
  assign vga_green_o    = r_rgb[7:4];
  assign vga_blue_o     = r_rgb[3:0];
  assign vga_hsync_o    = r_hsync;
  assign vga_vsync_o    = r_vsync;
  assign frame_tick_o   = r_frame_tick;
  assign active_image_o = r_active;

endmodule

// File: tb/tb_bouncing_screensaver.sv
// Bench for bouncing_screensaver: directed pixel/sync vectors push expected outputs into a
// queue; a monitor pops and compares them when they are due at the VGA outputs.
module tb_bouncing_screensaver;

  localparam logic [11:0] BG = 12'h5A3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [9:0] px, py;
  logic       vis, hs, vs;
  logic [3:0] sel;
  logic       auto_c, pause;

  // Main DUT: default geometry, 4 images, short auto-cycle period.
  logic [14:0] addr1;
  logic [47:0] rdata1;
  logic [3:0]  r1, g1, b1;
  logic        hs1, vs1, ft1;
  logic [1:0]  act1;

  // Corner DUT: 8x8 screen, 4x4 sprite, STEP=3, so both axes hit the wall together.
  logic [3:0]  addr2;
  logic [23:0] rdata2;
  logic [3:0]  r2, g2, b2;
  logic        hs2, vs2, ft2;
  logic [0:0]  act2;

  bouncing_screensaver #(
    .AUTO_CYCLE_FRAMES (3),
    .BG_COLOR          (BG)
  ) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .position_x_i   (px),
    .position_y_i   (py),
    .visible_i      (vis),
    .hsync_i        (hs),
    .vsync_i        (vs),
    .select_image_i (sel),
    .auto_cycle_i   (auto_c),
    .pause_i        (pause),
    .rom_addr_o     (addr1),
    .rom_rdata_i    (rdata1),
    .vga_red_o      (r1),
    .vga_green_o    (g1),
    .vga_blue_o     (b1),
    .vga_hsync_o    (hs1),
    .vga_vsync_o    (vs1),
    .frame_tick_o   (ft1),
    .active_image_o (act1)
  );

  bouncing_screensaver #(
    .NUM_IMAGES    (2),
    .IMAGE_WIDTH   (4),
    .IMAGE_HEIGHT  (4),
    .SCREEN_WIDTH  (8),
    .SCREEN_HEIGHT (8),
    .STEP          (3),
    .BG_COLOR      (BG)
  ) u_dut2 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .position_x_i   (px),
    .position_y_i   (py),
    .visible_i      (vis),
    .hsync_i        (hs),
    .vsync_i        (vs),
    .select_image_i (sel[1:0]),
    .auto_cycle_i   (auto_c),
    .pause_i        (pause),
    .rom_addr_o     (addr2),
    .rom_rdata_i    (rdata2),
    .vga_red_o      (r2),
    .vga_green_o    (g2),
    .vga_blue_o     (b2),
    .vga_hsync_o    (hs2),
    .vga_vsync_o    (vs2),
    .frame_tick_o   (ft2),
    .active_image_o (act2)
  );

  // ROM contents: image tag in the top bits, address in the low bits, offset so addr 0 != 0.
  function automatic logic [11:0] rom_fn(input int k, input int a);
    logic [11:0] v;
    v = 12'(((k & 3) << 10) | (a & 1023));
    return v + 12'h123;
  endfunction

  // One-cycle ROM read latency.
  always @(posedge clk) begin
    rdata1 <= {rom_fn(3, int'(addr1)), rom_fn(2, int'(addr1)),
               rom_fn(1, int'(addr1)), rom_fn(0, int'(addr1))};
    rdata2 <= {rom_fn(1, int'(addr2)), rom_fn(0, int'(addr2))};
  end

  typedef struct {
    int          due;
    int          dut;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  // Monitor: compare every expectation at its due cycle.
  initial begin : monitor
    exp_t        e;
    logic [11:0] g_rgb;
    logic        g_hs, g_vs;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.dut == 0) begin
          g_rgb = {r1, g1, b1};
          g_hs  = hs1;
          g_vs  = vs1;
        end else begin
          g_rgb = {r2, g2, b2};
          g_hs  = hs2;
          g_vs  = vs2;
        end
        n_vec++;
        if (e.due != cyc || g_rgb !== e.rgb || g_hs !== e.hs || g_vs !== e.vs) begin
          n_bad++;
          $display("FAIL %s: got rgb=%h hsync=%b vsync=%b at cycle %0d, want rgb=%h hsync=%b vsync=%b at cycle %0d",
                   e.name, g_rgb, g_hs, g_vs, cyc, e.rgb, e.hs, e.vs, e.due);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  // Drive one pixel cycle; who: 0 = main DUT, 1 = corner DUT, 2 = no expectation.
  task automatic vec(input int x, input int y, input logic v, input logic h, input logic s,
                     input int who, input logic [11:0] rgb, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    px  = 10'(x);
    py  = 10'(y);
    vis = v;
    hs  = h;
    vs  = s;
    if (who != 2) begin
      e.due  = cyc + 3;
      e.dut  = who;
      e.rgb  = rgb;
      e.hs   = h;
      e.vs   = s;
      e.name = nm;
      q.push_back(e);
    end
  endtask

  task automatic p1(input int x, input int y, input logic [11:0] rgb, input string nm);
    vec(x, y, 1'b1, 1'b1, 1'b1, 0, rgb, nm);
  endtask

  task automatic p2(input int x, input int y, input logic [11:0] rgb, input string nm);
    vec(x, y, 1'b1, 1'b1, 1'b1, 1, rgb, nm);
  endtask

  // One frame boundary: vsync falls for a cycle in blanking.
  task automatic tick(input string nm);
    vec(700, 500, 1'b0, 1'b1, 1'b0, 0, 12'h000, {nm, "_lo"});
    vec(700, 500, 1'b0, 1'b1, 1'b1, 0, 12'h000, {nm, "_hi"});
  endtask

  task automatic set_sel(input logic [3:0] v);
    @(posedge clk);
    #1;
    sel = v;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations still pending, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    px = '0; py = '0; vis = 1'b0; hs = 1'b1; vs = 1'b1; sel = '0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin : main
    rst_n = 1'b0;
    px = '0; py = '0; vis = 1'b0; hs = 1'b1; vs = 1'b1;
    sel = '0; auto_c = 1'b0; pause = 1'b0;

    // T1: reset values, basic pixel mapping, blanking, sync alignment, frame tick
    do_reset();
    chk("t1_rst_rgb", int'({r1, g1, b1}), 0);
    chk("t1_rst_hsync", int'(hs1), 1);
    chk("t1_rst_vsync", int'(vs1), 1);
    chk("t1_rst_tick", int'(ft1), 0);
    chk("t1_rst_active", int'(act1), 0);
    chk("t1_rst_addr", int'(addr1), 0);
    p1(0, 0, rom_fn(0, 0), "t1_px_0_0");
    p1(159, 119, rom_fn(0, 19199), "t1_px_159_119");
    p1(160, 0, BG, "t1_bg_160_0");
    p1(0, 120, BG, "t1_bg_0_120");
    vec(100, 50, 1'b1, 1'b0, 1'b1, 0, rom_fn(0, 8100), "t1_hsync_low");
    vec(650, 10, 1'b0, 1'b1, 1'b1, 0, 12'h000, "t1_blank");
    vec(0, 0, 1'b0, 1'b1, 1'b1, 0, 12'h000, "t1_blank_in_sprite");
    vec(700, 500, 1'b0, 1'b1, 1'b0, 0, 12'h000, "t1_vsync_low");
    vec(700, 500, 1'b0, 1'b1, 1'b1, 0, 12'h000, "t1_vsync_high");
    chk("t1_frame_tick_high", int'(ft1), 1);
    vec(700, 500, 1'b0, 1'b1, 1'b1, 0, 12'h000, "t1_idle");
    chk("t1_frame_tick_low", int'(ft1), 0);
    drain();

    // T2: bounce off right and bottom walls with STEP=1
    do_reset();
    for (int i = 0; i < 360; i++) tick("t2_tick");
    p1(360, 360, rom_fn(0, 0), "t2_org_360_360");
    p1(360, 359, BG, "t2_above_360");
    p1(359, 360, BG, "t2_left_360");
    for (int i = 0; i < 120; i++) tick("t2_tick");
    p1(480, 240, rom_fn(0, 0), "t2_org_480_240");
    p1(479, 240, BG, "t2_left_480");
    p1(639, 359, rom_fn(0, 19199), "t2_last_480_240");
    tick("t2_tick_flip");
    p1(479, 239, rom_fn(0, 0), "t2_org_479_239");
    p1(638, 358, rom_fn(0, 19199), "t2_last_479_239");
    p1(639, 358, BG, "t2_right_479");
    p1(479, 359, BG, "t2_below_239");
    drain();

    // T3: simultaneous corner flip with clamping (corner DUT, STEP=3, max 4)
    do_reset();
    tick("t3_tick1");
    tick("t3_tick2");
    p2(4, 4, rom_fn(0, 0), "t3_clamp_4_4");
    p2(7, 7, rom_fn(0, 15), "t3_last_4_4");
    p2(3, 4, BG, "t3_left_4_4");
    p2(4, 3, BG, "t3_above_4_4");
    tick("t3_tick3");
    p2(1, 1, rom_fn(0, 0), "t3_org_1_1");
    p2(4, 4, rom_fn(0, 15), "t3_last_1_1");
    p2(0, 1, BG, "t3_left_1_1");
    tick("t3_tick4");
    p2(0, 0, rom_fn(0, 0), "t3_org_0_0");
    p2(4, 0, BG, "t3_right_0_0");
    tick("t3_tick5");
    p2(3, 3, rom_fn(0, 0), "t3_org_3_3");
    p2(2, 3, BG, "t3_left_3_3");
    drain();

    // T4: manual select applies only at the next tick; invalid patterns hold
    do_reset();
    set_sel(4'b0100);
    p1(0, 0, rom_fn(0, 0), "t4_no_tear");
    set_sel(4'b0000);
    p1(0, 0, rom_fn(0, 0), "t4_still_img0");
    chk("t4_active_before_tick", int'(act1), 0);
    tick("t4_tick1");
    chk("t4_active_after_tick", int'(act1), 2);
    p1(1, 1, rom_fn(2, 0), "t4_img2_org_1_1");
    p1(0, 0, BG, "t4_bg_0_0");
    set_sel(4'b0110);
    set_sel(4'b0000);
    tick("t4_tick2");
    chk("t4_active_hold", int'(act1), 2);
    p1(2, 2, rom_fn(2, 0), "t4_img2_org_2_2");
    drain();

    // T5: auto-cycle every 3 frames, wrap, and manual select restarting the count
    do_reset();
    pause  = 1'b1;
    auto_c = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      tick("t5_tick");
      chk("t5_auto_active", int'(act1), ((t - 1) / 3) % 4);
      p1(0, 0, rom_fn(((t - 1) / 3) % 4, 0), "t5_auto_pixel");
    end
    set_sel(4'b0010);
    set_sel(4'b0000);
    tick("t5_sel_a");
    chk("t5_sel_active_a", int'(act1), 1);
    tick("t5_sel_b");
    chk("t5_sel_active_b", int'(act1), 1);
    p1(0, 0, rom_fn(1, 0), "t5_sel_pixel_b");
    tick("t5_sel_c");
    chk("t5_sel_active_c", int'(act1), 1);
    tick("t5_sel_d");
    chk("t5_sel_active_d", int'(act1), 2);
    p1(0, 0, rom_fn(2, 0), "t5_sel_pixel_d");
    auto_c = 1'b0;
    drain();

    // T6: pause holds the origin; asynchronous reset mid-line
    do_reset();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("t6_pause_tick");
      p1(0, 0, rom_fn(0, 0), "t6_paused_org");
    end
    p1(159, 119, rom_fn(0, 19199), "t6_paused_last");
    pause = 1'b0;
    set_sel(4'b1000);
    set_sel(4'b0000);
    tick("t6_run_tick");
    chk("t6_active_pre_reset", int'(act1), 3);
    p1(1, 1, rom_fn(3, 0), "t6_org_1_1");
    drain();
    for (int i = 0; i < 4; i++) vec(5, 5, 1'b1, 1'b0, 1'b1, 2, 12'h000, "");
    chk("t6_hsync_before_reset", int'(hs1), 0);
    chk("t6_rgb_before_reset", int'({r1, g1, b1}), int'(rom_fn(3, 644)));
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_rgb", int'({r1, g1, b1}), 0);
    chk("t6_async_hsync", int'(hs1), 1);
    chk("t6_async_vsync", int'(vs1), 1);
    chk("t6_async_active", int'(act1), 0);
    chk("t6_async_addr", int'(addr1), 0);
    px = '0; py = '0; vis = 1'b0; hs = 1'b1; vs = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    p1(0, 0, rom_fn(0, 0), "t6_org_after_reset");
    p1(0, 120, BG, "t6_bg_after_reset");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
